// File: rtl/ball_physics.sv
// Per-frame ball movement for pong: wall/paddle bounces, progressive speed-up,
// scoring and the IDLE/SERVE/PLAY/OVER sequencing, all stepped once per frame tick.
module ball_physics #(
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480,
    parameter int WALL_MARGIN      = 10,
    parameter int BALL_SIZE        = 10,
    parameter int PADDLE_LENGTH    = 50,
    parameter int PADDLE_WIDTH     = 5,
    parameter int PADDLE_ONE_X     = 30,
    parameter int PADDLE_TWO_X     = 600,
    parameter int SPEED_INIT       = 2,
    parameter int SPEED_MAX        = 6,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SERVE_FRAMES     = 60,
    parameter int WIN_SCORE        = 9,
    parameter int SCORE_W          = 4
) (
    input  logic               clk50M,
    input  logic               reset,
    input  logic               endofframe,
    input  logic               start,
    input  logic [9:0]         paddle_one_y,
    input  logic [9:0]         paddle_two_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic               collided,
    output logic               missed,
    output logic [SCORE_W-1:0] score_one,
    output logic [SCORE_W-1:0] score_two,
    output logic               game_over,
    output logic [1:0]         state
);
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] CX        = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] CY        = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] Y_TOP     = 11'(WALL_MARGIN);
    localparam logic [10:0] Y_LIM     = 11'(SCREEN_H - WALL_MARGIN);
    localparam logic [10:0] Y_BOT     = 11'(SCREEN_H - WALL_MARGIN - BALL_SIZE);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] BSZ_M1    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] PLEN_M1   = 11'(PADDLE_LENGTH - 1);
    localparam logic [10:0] P1_X      = 11'(PADDLE_ONE_X);
    localparam logic [10:0] P1_FACE   = 11'(PADDLE_ONE_X + PADDLE_WIDTH);
    localparam logic [10:0] P1_BOUNCE = 11'(PADDLE_ONE_X + PADDLE_WIDTH + 1);
    localparam logic [10:0] P2_X      = 11'(PADDLE_TWO_X);
    localparam logic [10:0] P2_BACK   = 11'(PADDLE_TWO_X + PADDLE_WIDTH - 1);
    localparam logic [10:0] P2_BOUNCE = 11'(PADDLE_TWO_X - BALL_SIZE);
    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - 1);

    localparam logic [SPD_W-1:0]   S_INIT     = SPD_W'(SPEED_INIT);
    localparam logic [SPD_W-1:0]   S_MAX      = SPD_W'(SPEED_MAX);
    localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_SPEEDUP - 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_eof_q;
    logic [9:0]         r_ball_x;
    logic [9:0]         r_ball_y;
    logic               r_dir_x;     // 1 = moving right
    logic               r_dir_y;     // 1 = moving down
    logic [SPD_W-1:0]   r_speed;
    logic [HIT_W-1:0]   r_hits;
    logic [CNT_W-1:0]   r_serve_cnt;
    logic [SCORE_W-1:0] r_score_one;
    logic [SCORE_W-1:0] r_score_two;
    logic               r_collided;
    logic               r_missed;
    logic               r_game_over;

    logic               w_tick;
    logic [10:0]        w_bx;
    logic [10:0]        w_by;
    logic [10:0]        w_s;
    logic [10:0]        w_p1;
    logic [10:0]        w_p2;
    logic [9:0]         w_y_next;
    logic               w_dy_next;
    logic [9:0]         w_x_step;
    logic               w_ov1;
    logic               w_ov2;
    logic               w_hit_l;
    logic               w_hit_r;
    logic               w_miss_l;
    logic               w_miss_r;
    logic [SCORE_W-1:0] w_s1_inc;
    logic [SCORE_W-1:0] w_s2_inc;

    assign w_tick = endofframe & ~r_eof_q;

    // Positions are widened to 11 bits so the edge comparisons never wrap.
    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {1'b0, r_ball_y};
    assign w_s  = 11'(r_speed);
    assign w_p1 = {1'b0, paddle_one_y};
    assign w_p2 = {1'b0, paddle_two_y};

    always_comb begin
        w_y_next  = r_ball_y;
        w_dy_next = r_dir_y;
        if (r_dir_y) begin
            if (w_by + w_s + BSZ > Y_LIM) begin
                w_y_next  = 10'(Y_BOT);
                w_dy_next = 1'b0;
            end else begin
                w_y_next = 10'(w_by + w_s);
            end
        end else if (w_by < Y_TOP + w_s) begin
            w_y_next  = 10'(Y_TOP);
            w_dy_next = 1'b1;
        end else begin
            w_y_next = 10'(w_by - w_s);
        end
    end

    assign w_x_step = r_dir_x ? 10'(w_bx + w_s) : 10'(w_bx - w_s);

    assign w_ov1 = (w_by + BSZ_M1 >= w_p1) && (w_by <= w_p1 + PLEN_M1);
    assign w_ov2 = (w_by + BSZ_M1 >= w_p2) && (w_by <= w_p2 + PLEN_M1);

    // The left test is rearranged as x <= face + s; x > P1_X already keeps x above s.
    assign w_hit_l  = !r_dir_x && (w_bx <= P1_FACE + w_s) && (w_bx > P1_X) && w_ov1;
    assign w_hit_r  = r_dir_x && (w_bx + BSZ_M1 + w_s >= P2_X) && (w_bx + BSZ_M1 < P2_BACK) && w_ov2;
    assign w_miss_l = !r_dir_x && !w_hit_l && (w_bx < w_s);
    assign w_miss_r = r_dir_x && !w_hit_r && (w_bx + BSZ_M1 + w_s > X_MAX);

    assign w_s1_inc = (r_score_one >= WIN) ? WIN : r_score_one + 1'b1;
    assign w_s2_inc = (r_score_two >= WIN) ? WIN : r_score_two + 1'b1;

    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_eof_q     <= 1'b0;
            r_ball_x    <= 10'(CX);
            r_ball_y    <= 10'(CY);
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_speed     <= S_INIT;
            r_hits      <= '0;
            r_serve_cnt <= '0;
            r_score_one <= '0;
            r_score_two <= '0;
            r_collided  <= 1'b0;
            r_missed    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_eof_q    <= endofframe;
            r_collided <= 1'b0;
            r_missed   <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state     <= SERVE;
                            r_serve_cnt <= '0;
                        end
                    end
                    SERVE: begin
                        if (r_serve_cnt == SERVE_LAST) begin
                            r_state <= PLAY;
                            r_speed <= S_INIT;
                            r_hits  <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 1'b1;
                        end
                    end
                    PLAY: begin
                        r_ball_y <= w_y_next;
                        r_dir_y  <= w_dy_next;
                        if (w_hit_l || w_hit_r) begin
                            r_ball_x   <= w_hit_l ? 10'(P1_BOUNCE) : 10'(P2_BOUNCE);
                            r_dir_x    <= w_hit_l;
                            r_collided <= 1'b1;
                            if (r_hits == HIT_LAST) begin
                                r_hits <= '0;
                                if (r_speed < S_MAX) r_speed <= r_speed + 1'b1;
                            end else begin
                                r_hits <= r_hits + 1'b1;
                            end
                        end else if (w_miss_l || w_miss_r) begin
                            // Re-serve from the centre, heading toward whoever conceded.
                            r_missed    <= 1'b1;
                            r_ball_x    <= 10'(CX);
                            r_ball_y    <= 10'(CY);
                            r_dir_x     <= w_miss_r;
                            r_speed     <= S_INIT;
                            r_serve_cnt <= '0;
                            if (w_miss_l) r_score_two <= w_s2_inc;
                            else          r_score_one <= w_s1_inc;
                            if ((w_miss_l && w_s2_inc == WIN) || (w_miss_r && w_s1_inc == WIN)) begin
                                r_state     <= OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= SERVE;
                            end
                        end else begin
                            r_ball_x <= w_x_step;
                        end
                    end
                    OVER: begin
                        if (start) begin
                            r_state     <= SERVE;
                            r_game_over <= 1'b0;
                            r_score_one <= '0;
                            r_score_two <= '0;
                            r_ball_x    <= 10'(CX);
                            r_ball_y    <= 10'(CY);
                            r_dir_x     <= 1'b1;
                            r_serve_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign collided  = r_collided;
    assign missed    = r_missed;
    assign score_one = r_score_one;
    assign score_two = r_score_two;
    assign game_over = r_game_over;
    assign state     = r_state;
endmodule

// File: tb/tb_ball_physics.sv
// Randomised bench for ball_physics: a frame-level reference model predicts the
// registered outputs for every clock, and a monitor compares them one clock later.
module tb_ball_physics;
    localparam int CX = 315;
    localparam int CY = 235;

    logic       clk50M = 1'b0;
    logic       reset;
    logic       endofframe;
    logic       start;
    logic [9:0] paddle_one_y;
    logic [9:0] paddle_two_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       collided;
    logic       missed;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic       game_over;
    logic [1:0] state;

    ball_physics dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .endofframe  (endofframe),
        .start       (start),
        .paddle_one_y(paddle_one_y),
        .paddle_two_y(paddle_two_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .collided    (collided),
        .missed      (missed),
        .score_one   (score_one),
        .score_two   (score_two),
        .game_over   (game_over),
        .state       (state)
    );

    always #10 clk50M = ~clk50M;

    typedef struct packed {
        logic [1:0] st;
        logic [9:0] x;
        logic [9:0] y;
        logic       col;
        logic       mis;
        logic       go;
        logic [3:0] s1;
        logic [3:0] s2;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int overs    = 0;

    // Reference model state (game-level quantities, plain integers)
    int m_st, m_x, m_y, m_dx, m_dy, m_spd, m_hits, m_cnt, m_s1, m_s2, m_col, m_mis, m_eofq;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_spd = 2; m_hits = 0;
        m_cnt = 0; m_s1 = 0; m_s2 = 0; m_col = 0; m_mis = 0; m_eofq = 0;
    endtask

    task automatic model_tick(input logic st_in);
        int s, ny, ndy, p1, p2, nsc;
        bit hl, hr, ml, mr;
        p1 = int'(paddle_one_y);
        p2 = int'(paddle_two_y);
        case (m_st)
            0: if (st_in) begin m_st = 1; m_cnt = 0; end
            1: begin
                if (m_cnt == 59) begin m_st = 2; m_spd = 2; m_hits = 0; end
                else m_cnt++;
            end
            2: begin
                s = m_spd;
                ndy = m_dy;
                if (m_dy == 1) begin
                    if (m_y + s + 10 > 470) begin ny = 460; ndy = 0; end
                    else ny = m_y + s;
                end else begin
                    if (m_y < 10 + s) begin ny = 10; ndy = 1; end
                    else ny = m_y - s;
                end
                hl = (m_dx == 0) && (m_x - s <= 35) && (m_x > 30) && (m_y + 9 >= p1) && (m_y <= p1 + 49);
                hr = (m_dx == 1) && (m_x + 9 + s >= 600) && (m_x + 9 < 604) && (m_y + 9 >= p2) && (m_y <= p2 + 49);
                ml = (m_dx == 0) && !hl && (m_x < s);
                mr = (m_dx == 1) && !hr && (m_x + 9 + s > 639);
                m_y = ny;
                m_dy = ndy;
                if (hl || hr) begin
                    m_x = hl ? 36 : 590;
                    m_dx = hl ? 1 : 0;
                    m_col = 1;
                    m_hits++;
                    if (m_hits == 4) begin
                        m_hits = 0;
                        m_spd = (m_spd + 1 > 6) ? 6 : m_spd + 1;
                    end
                end else if (ml || mr) begin
                    m_mis = 1;
                    m_x = CX;
                    m_y = CY;
                    m_dx = mr ? 1 : 0;
                    m_spd = 2;
                    m_cnt = 0;
                    if (ml) begin m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1; nsc = m_s2; end
                    else    begin m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1; nsc = m_s1; end
                    if (nsc == 9) begin m_st = 3; overs++; end
                    else m_st = 1;
                end else begin
                    m_x = (m_dx == 1) ? m_x + s : m_x - s;
                end
            end
            default: begin
                if (st_in) begin
                    m_s1 = 0; m_s2 = 0; m_x = CX; m_y = CY; m_dx = 1; m_st = 1; m_cnt = 0;
                end
            end
        endcase
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st  = 2'(m_st);
        e.x   = 10'(m_x);
        e.y   = 10'(m_y);
        e.col = m_col[0];
        e.mis = m_mis[0];
        e.go  = (m_st == 3);
        e.s1  = 4'(m_s1);
        e.s2  = 4'(m_s2);
        return e;
    endfunction

    // One clock: drive inputs after a falling edge, predict what the next rising edge registers.
    task automatic cycle(input logic e, input logic s);
        endofframe = e;
        start      = s;
        m_col = 0;
        m_mis = 0;
        if (e && m_eofq == 0) model_tick(s);
        m_eofq = e ? 1 : 0;
        q.push_back(snap());
        @(negedge clk50M);
    endtask

    function automatic int pick_paddle(input int skill);
        int v;
        if ($urandom_range(0, 99) < skill) begin
            v = m_y - int'($urandom_range(0, 40));
            return (v < 0) ? 0 : v;
        end
        return int'($urandom_range(0, 430));
    endfunction

    task automatic frame(input int hi, input int lo, input logic s);
        paddle_one_y = 10'(pick_paddle(85));
        paddle_two_y = 10'(pick_paddle(45));
        for (int i = 0; i < hi; i++) cycle(1'b1, s);
        for (int i = 0; i < lo; i++) cycle(1'b0, 1'b0);
    endtask

    // Monitor: one prediction per clock, compared just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk50M);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",     int'(state),     int'(e.st));
                chk("ball_x",    int'(ball_x),    int'(e.x));
                chk("ball_y",    int'(ball_y),    int'(e.y));
                chk("collided",  int'(collided),  int'(e.col));
                chk("missed",    int'(missed),    int'(e.mis));
                chk("game_over", int'(game_over), int'(e.go));
                chk("score_one", int'(score_one), int'(e.s1));
                chk("score_two", int'(score_two), int'(e.s2));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},  int'(state),     0);
        chk({tag, "_ball_x"}, int'(ball_x),    CX);
        chk({tag, "_ball_y"}, int'(ball_y),    CY);
        chk({tag, "_scores"}, int'({score_one, score_two}), 0);
        chk({tag, "_pulses"}, int'({collided, missed, game_over}), 0);
    endtask

    initial begin
        int fr, after, guard;
        reset        = 1'b0;
        endofframe   = 1'b0;
        start        = 1'b0;
        paddle_one_y = '0;
        paddle_two_y = '0;
        model_reset();
        @(negedge clk50M);
        @(negedge clk50M);
        check_reset_values("por");
        reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);

        fr = 0;
        after = 0;
        while (fr < 12000 && !(overs > 0 && m_st == 2 && after > 100)) begin
            frame((fr == 400) ? 1000 : int'($urandom_range(1, 2)),
                  int'($urandom_range(1, 2)),
                  ($urandom_range(0, 99) < 10));
            fr++;
            if (overs > 0) after++;
        end

        // Bring the game into PLAY, then pull reset asynchronously between clock edges.
        guard = 0;
        while (m_st != 2 && guard < 500) begin
            frame(1, 1, 1'b1);
            guard++;
        end
        chk("in_play_before_reset", m_st, 2);
        @(posedge clk50M);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk50M);
        reset = 1'b1;
        model_reset();
        frame(1, 1, 1'b1);
        for (int i = 0; i < 70; i++) frame(1, 1, 1'b0);

        repeat (2) @(posedge clk50M);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
